// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: widths, the
// divide-by-zero quotient and the FSM state encoding.
package div_pkg;

    localparam int unsigned DIV_W = 8;
    localparam logic [DIV_W-1:0] DBZ_QUOT = 8'hFF;
    localparam int unsigned CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_8bit_seq_addsub.sv
// Combinational adder/subtractor used as the divider's trial subtractor.
// Ports:
//   a, b      operands
//   sel       0: a + b, 1: a - b
//   result_c  low W bits of the result
//   cout_c    carry out on add; borrow (1 = a < b) on subtract
module div_8bit_seq_addsub #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] result_c,
    output logic         cout_c
);

    logic [W:0] full;

    // Zero-extended arithmetic: bit W is carry on add, borrow on subtract.
    always_comb begin
        if (sel) begin
            full = {1'b0, a} - {1'b0, b};
        end else begin
            full = {1'b0, a} + {1'b0, b};
        end
    end

    assign result_c = full[W-1:0];
    assign cout_c   = full[W];

endmodule

// File: rtl/div_8bit_seq.sv
// Iterative unsigned restoring divider, one trial subtraction per clock.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request, accepted in IDLE or DONE
//   dividend      numerator, latched on accepted start
//   divisor       denominator, latched on accepted start
//   busy          high while iterating
//   done          one-cycle pulse, results valid from this cycle
//   quotient      registered quotient, held until next completion
//   remainder     registered remainder, held until next completion
//   div_by_zero   set with done when the divisor was zero
module div_8bit_seq
    import div_pkg::*;
#(
    parameter int unsigned     WIDTH    = DIV_W,
    parameter logic [WIDTH-1:0] DBZ_Q   = DBZ_QUOT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] q_w, q_w_nxt;
    logic [WIDTH-1:0] r_w, r_w_nxt;
    logic [WIDTH-1:0] d_w, d_w_nxt;
    logic             dbz_pend, dbz_pend_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quot_nxt, rem_nxt;

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] diff_c;
    logic             sub_borrow_c;
    logic             borrow;
    logic [WIDTH-1:0] r_step, q_step;

    // Partial remainder shifted left with the next dividend bit.
    assign s = {r_w, q_w[WIDTH-1]};

    div_8bit_seq_addsub #(.W(WIDTH)) u_trial (
        .a        (s[WIDTH-1:0]),
        .b        (d_w),
        .sel      (1'b1),
        .result_c (diff_c),
        .cout_c   (sub_borrow_c)
    );

    // With the top bit of s set the trial always succeeds; the low bits of
    // the modular difference are still the correct new remainder.
    assign borrow = sub_borrow_c & ~s[WIDTH];
    assign r_step = borrow ? s[WIDTH-1:0] : diff_c;
    assign q_step = {q_w[WIDTH-2:0], ~borrow};

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        q_w_nxt      = q_w;
        r_w_nxt      = r_w;
        d_w_nxt      = d_w;
        dbz_pend_nxt = 1'b0;
        quot_nxt     = quotient;
        rem_nxt      = remainder;
        dbz_nxt      = div_by_zero;

        case (state)
            IDLE, DONE: begin
                if (dbz_pend) begin
                    // Divide-by-zero reports one cycle after acceptance,
                    // matching the operand-latch cycle of a normal division.
                    state_nxt = DONE;
                    quot_nxt  = DBZ_Q;
                    rem_nxt   = q_w;
                    dbz_nxt   = 1'b1;
                end else if (start) begin
                    q_w_nxt = dividend;
                    r_w_nxt = '0;
                    d_w_nxt = divisor;
                    cnt_nxt = '0;
                    if (divisor != '0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt    = IDLE;
                        dbz_pend_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                q_w_nxt = q_step;
                r_w_nxt = r_step;
                cnt_nxt = CW'(cnt + 1'b1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                    quot_nxt  = q_step;
                    rem_nxt   = r_step;
                    dbz_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
    end

    // State, working and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            q_w         <= '0;
            r_w         <= '0;
            d_w         <= '0;
            dbz_pend    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            q_w         <= q_w_nxt;
            r_w         <= r_w_nxt;
            d_w         <= d_w_nxt;
            dbz_pend    <= dbz_pend_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            quotient    <= quot_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

endmodule
